// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and sequencer state encoding for the FIR sample sequencer.
package fir_pkg;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 7;
  localparam int MEM_DEPTH = 128;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
endpackage

// File: rtl/rd_flag_pipe.sv
// rd_flag_pipe: DEPTH-stage shift of {valid, last, zero} aligned with RAM read latency.
module rd_flag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] d,
  output logic [2:0] q
);
  logic [2:0] sr [DEPTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/fir_sample_seq.sv
// fir_sample_seq: writes each accepted sample to RAM, then streams NTAPS taps newest-first to the MAC.
module fir_sample_seq
  import fir_pkg::*;
#(
  parameter int NTAPS = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);
  localparam logic [7:0] LAST_K = 8'(NTAPS - 1);
  localparam logic [7:0] LAST_D = 8'(RD_LAT - 1);
  localparam logic [7:0] FULL = 8'(NTAPS);
  state_t state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0] cnt, fill;
  logic [2:0] flag_in, flag_out;
  assign s_ready = state == IDLE;
  assign busy = state != IDLE;
  // taps beyond the number of samples written since reset read stale RAM, so mark them zero
  always_comb flag_in = state == READ ? {1'b1, cnt == LAST_K, cnt >= fill} : 3'b000;
  rd_flag_pipe #(.DEPTH(RD_LAT)) u_flags (
    .clk(clk),
    .reset(reset),
    .d(flag_in),
    .q(flag_out)
  );
  assign m_valid = flag_out[2];
  assign m_last = flag_out[1];
  assign m_data = flag_out[2] && !flag_out[0] ? ram_dout : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      fill <= '0;
      cnt <= '0;
      ram_ce <= 1'b0;
      ram_oce <= 1'b0;
      ram_wre <= 1'b0;
      ram_ad <= '0;
      ram_din <= '0;
    end else begin
      unique case (state)
        IDLE: if (s_valid) begin
          state <= WRITE;
          ram_ce <= 1'b1;
          ram_wre <= 1'b1;
          ram_ad <= wr_ptr;
          ram_din <= s_data;
          fill <= fill == FULL ? fill : fill + 8'd1;
        end
        WRITE: begin
          // ram_ad keeps the written address so read k=0 returns the new sample
          state <= READ;
          ram_wre <= 1'b0;
          ram_oce <= 1'b1;
          wr_ptr <= wr_ptr + 1'b1;
          cnt <= '0;
        end
        READ: begin
          ram_ad <= ram_ad - 1'b1;
          cnt <= cnt + 8'd1;
          if (cnt == LAST_K) begin
            state <= DRAIN;
            ram_ce <= 1'b0;
            cnt <= '0;
          end
        end
        DRAIN: begin
          cnt <= cnt + 8'd1;
          if (cnt == LAST_D) begin
            state <= IDLE;
            ram_oce <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_sample_seq.sv
// tb_fir_sample_seq: directed vectors for the FIR sample sequencer with a 2-cycle-latency RAM model.
module tb_fir_sample_seq;
  logic clk = 1'b0;
  logic reset, s_valid, s_ready, m_valid, m_last, busy;
  logic ram_ce, ram_oce, ram_wre, scramble;
  logic [17:0] s_data, m_data, ram_din, ram_dout;
  logic [6:0] ram_ad;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  fir_sample_seq #(.NTAPS(4), .RD_LAT(2)) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .ram_ce(ram_ce),
    .ram_oce(ram_oce),
    .ram_wre(ram_wre),
    .ram_ad(ram_ad),
    .ram_din(ram_din),
    .ram_dout(ram_dout),
    .busy(busy)
  );
  logic [17:0] mem [128];
  logic [17:0] r1, r2;
  always @(posedge clk) begin
    if (scramble) for (int i = 0; i < 128; i++) mem[i] <= 18'h2AAAA ^ 18'(i);
    if (reset) begin
      r1 <= '0;
      r2 <= '0;
    end else begin
      if (ram_ce && ram_wre) mem[ram_ad] <= ram_din;
      if (ram_ce && !ram_wre) r1 <= mem[ram_ad];
      if (ram_oce) r2 <= r1;
    end
  end
  assign ram_dout = r2;
  typedef struct packed {
    logic [17:0] sample;
    logic [6:0] wad;
    logic [3:0][17:0] taps;
  } vec_t;
  vec_t vecs [6];
  function automatic vec_t mk(logic [17:0] s, logic [6:0] w, logic [17:0] a, b, c, d);
    return '{s, w, {d, c, b, a}};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset;
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    tick;
    reset = 1'b0;
  endtask
  task automatic do_sample(input logic [17:0] v, input logic [6:0] wad, input logic [3:0][17:0] exp);
    logic seq_ok;
    logic [6:0] ad [4];
    logic [17:0] tap [4];
    seq_ok = s_ready && !busy;
    s_valid = 1'b1;
    s_data = v;
    tick;
    s_valid = 1'b0;
    s_data = '0;
    seq_ok &= ram_ce && ram_wre && !ram_oce && !s_ready && busy && !m_valid;
    chk("wr_ad", 32'(ram_ad), 32'(wad));
    chk("wr_din", 32'(ram_din), 32'(v));
    for (int c = 2; c < 8; c++) begin
      tick;
      if (c < 6) begin
        ad[c-2] = ram_ad;
        seq_ok &= ram_ce && !ram_wre && ram_oce;
      end else seq_ok &= !ram_ce && !ram_wre && ram_oce;
      if (c < 4) seq_ok &= !m_valid && !m_last && m_data == '0;
      else begin
        tap[c-4] = m_data;
        seq_ok &= m_valid && (m_last == (c == 7));
      end
      seq_ok &= !s_ready && busy;
    end
    tick;
    seq_ok &= s_ready && !busy && !m_valid && !m_last && m_data == '0 && !ram_oce && !ram_ce;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd_ad%0d", k), 32'(ad[k]), 32'(7'(wad - 7'(k))));
      chk($sformatf("tap%0d", k), 32'(tap[k]), 32'(exp[k]));
    end
    chk("seq", 32'(seq_ok), 32'd1);
  endtask
  initial begin
    logic [3:0][17:0] e;
    int acc [$];
    int lows, nv;
    vecs[0] = mk(18'd1, 7'd0, 18'd1, 18'd0, 18'd0, 18'd0);
    vecs[1] = mk(18'd2, 7'd1, 18'd2, 18'd1, 18'd0, 18'd0);
    vecs[2] = mk(18'd3, 7'd2, 18'd3, 18'd2, 18'd1, 18'd0);
    vecs[3] = mk(18'd4, 7'd3, 18'd4, 18'd3, 18'd2, 18'd1);
    vecs[4] = mk(18'd5, 7'd4, 18'd5, 18'd4, 18'd3, 18'd2);
    vecs[5] = mk(18'h3FFFF, 7'd5, 18'h3FFFF, 18'd5, 18'd4, 18'd3);
    scramble = 1'b1;
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    tick;
    scramble = 1'b0;
    do_reset;
    chk("rst_ready_busy", {30'd0, s_ready, busy}, 32'd2);
    chk("rst_m", {13'd0, m_valid, m_last, m_data}, 32'd0);
    chk("rst_ram_ctl", {29'd0, ram_ce, ram_oce, ram_wre}, 32'd0);
    chk("rst_ram_ad_din", {7'd0, ram_ad, ram_din}, 32'd0);
    for (int i = 0; i < 3; i++) tick;
    chk("idle", {28'd0, s_ready, m_valid, ram_ce, ram_wre}, 32'd8);
    chk("idle_ad", 32'(ram_ad), 32'd0);
    foreach (vecs[i]) do_sample(vecs[i].sample, vecs[i].wad, vecs[i].taps);
    do_reset;
    for (int i = 0; i < 130; i++) begin
      for (int k = 0; k < 4; k++) e[k] = i - k >= 0 ? 18'(i - k) : '0;
      do_sample(18'(i), 7'(i), e);
    end
    do_reset;
    s_valid = 1'b1;
    s_data = 18'h11;
    lows = 0;
    for (int c = 0; c < 33; c++) begin
      if (s_ready) acc.push_back(c);
      else lows++;
      tick;
    end
    s_valid = 1'b0;
    chk("cont_accepts", 32'(acc.size()), 32'd5);
    for (int i = 1; i < acc.size(); i++) chk($sformatf("cont_gap%0d", i), 32'(acc[i] - acc[i-1]), 32'd8);
    chk("cont_lows", 32'(lows), 32'd28);
    for (int i = 0; i < 8; i++) tick;
    do_reset;
    s_valid = 1'b1;
    s_data = 18'd9;
    tick;
    s_valid = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_state", {26'd0, s_ready, busy, m_valid, ram_ce, ram_oce, ram_wre}, 32'h20);
    chk("mid_rst_ad", 32'(ram_ad), 32'd0);
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid) nv++;
      tick;
    end
    chk("mid_rst_no_valid", 32'(nv), 32'd0);
    do_sample(18'd7, 7'd0, {18'd0, 18'd0, 18'd0, 18'd7});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
